// File: rtl/instr_fetch.sv
// Instruction prefetch queue: issues byte fetches ahead of the pipeline into a small circular FIFO.
// Optional macro INSTR_FETCH_BYPASS_EN forwards a response straight to INSTR when the queue is empty.
module instr_fetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        CLK,
    input  logic        RST_bar,
    output logic [15:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic        MEM_GNT,
    input  logic [7:0]  MEM_DATA,
    output logic [7:0]  INSTR,
    output logic        INSTR_VALID,
    input  logic        INSTR_TAKE,
    input  logic        JUMP,
    input  logic [15:0] JUMP_ADDR,
    input  logic        HALT,
    output logic [15:0] PC
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;
    logic             inflight_reg;
    logic [15:0]      fetch_addr_reg;
    logic [15:0]      pc_reg;

    logic [OCC_W-1:0] occupancy;
    logic             queue_empty;
    logic             issue;
    logic             resp_arrive;
    logic             bypass_valid;
    logic             take;
    logic             wr_en;
    logic             rd_en;

    // In-flight byte counts against capacity so a response always has a slot.
    assign occupancy   = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    assign queue_empty = (count_reg == '0);
    assign MEM_RD      = RST_bar && !HALT && !JUMP && (occupancy < OCC_W'(FIFO_DEPTH));
    assign issue       = MEM_RD && MEM_GNT;
    assign MEM_ADDR    = fetch_addr_reg;
    assign PC          = pc_reg;

    // A response arriving in a JUMP cycle belongs to the old stream and is dropped.
    assign resp_arrive = inflight_reg && !JUMP;

`ifdef INSTR_FETCH_BYPASS_EN
    assign bypass_valid = queue_empty && resp_arrive;
`else
    assign bypass_valid = 1'b0;
`endif

    always_comb begin
        INSTR_VALID = !queue_empty || bypass_valid;
        INSTR       = 8'h00;
        if (!queue_empty) begin
            INSTR = fifo_mem[head_reg];
        end else if (bypass_valid) begin
            INSTR = MEM_DATA;
        end
    end

    assign take  = INSTR_TAKE && INSTR_VALID && !JUMP;
    // A bypassed byte consumed in its arrival cycle never enters the queue.
    assign wr_en = resp_arrive && !(bypass_valid && take);
    assign rd_en = take && !queue_empty;

    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            inflight_reg   <= 1'b0;
            fetch_addr_reg <= RESET_PC;
            pc_reg         <= RESET_PC;
        end else if (JUMP) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            inflight_reg   <= 1'b0;
            fetch_addr_reg <= JUMP_ADDR;
            pc_reg         <= JUMP_ADDR;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                fetch_addr_reg <= fetch_addr_reg + 16'd1;
            end
            if (take) begin
                pc_reg <= pc_reg + 16'd1;
            end
            if (wr_en) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (rd_en) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset; contents are only visible through a non-zero count.
    always_ff @(posedge CLK) begin
        if (RST_bar && wr_en) begin
            fifo_mem[tail_reg] <= MEM_DATA;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: issued fetches feed an expected-byte queue,
// a monitor compares INSTR/INSTR_VALID/PC every cycle and pops on each take.
module tb_instr_fetch;

    localparam int          FIFO_DEPTH = 4;
    localparam logic [15:0] RESET_PC   = 16'h0000;
`ifdef INSTR_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_bar = 1'b0;
    logic [15:0] MEM_ADDR;
    logic        MEM_RD;
    logic        MEM_GNT = 1'b0;
    logic [7:0]  MEM_DATA = 8'h00;
    logic [7:0]  INSTR;
    logic        INSTR_VALID;
    logic        INSTR_TAKE = 1'b0;
    logic        JUMP = 1'b0;
    logic [15:0] JUMP_ADDR = 16'h0000;
    logic        HALT = 1'b0;
    logic [15:0] PC;

    instr_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RST_bar(RST_bar), .MEM_ADDR(MEM_ADDR), .MEM_RD(MEM_RD),
        .MEM_GNT(MEM_GNT), .MEM_DATA(MEM_DATA), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .INSTR_TAKE(INSTR_TAKE), .JUMP(JUMP), .JUMP_ADDR(JUMP_ADDR), .HALT(HALT), .PC(PC)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] addr;
        int          cyc;
    } ent_t;

    ent_t        exp_q[$];
    logic [15:0] exp_pc = RESET_PC;
    logic [15:0] nf = RESET_PC;
    logic        last_issue = 1'b0;
    logic [15:0] last_addr = 16'h0000;
    logic        mon_en = 1'b0;
    logic        rst_req = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_issue = 0;

    // Memory content: mixes both address bytes so high-byte errors show up.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic gnt, input logic halt, input logic take,
                        input logic jump, input logic [15:0] jaddr);
        logic exp_rd;
        @(negedge CLK);
        cyc++;
        RST_bar    = rst_req;
        mon_en     = rst_req;
        MEM_DATA   = last_issue ? mem_byte(last_addr) : 8'($urandom);
        MEM_GNT    = gnt;
        HALT       = halt;
        INSTR_TAKE = take;
        JUMP       = jump;
        JUMP_ADDR  = jaddr;
        #1;
        exp_rd = mon_en && (exp_q.size() < FIFO_DEPTH) && !halt && !jump;
        chk("mem_rd", 32'(MEM_RD), 32'(exp_rd));
        if (exp_rd) chk("mem_addr", 32'(MEM_ADDR), 32'(nf));
        last_issue = MEM_RD && MEM_GNT;
        last_addr  = MEM_ADDR;
        if (last_issue) begin
            exp_q.push_back('{nf, cyc});
            $display("cycle %0d: issue fetch %h", cyc, nf);
            n_issue++;
            nf = nf + 16'd1;
        end
        if (jump) nf = jaddr;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_valid"}, 32'(INSTR_VALID), 32'd0);
        chk({tag, "_instr"}, 32'(INSTR), 32'd0);
        chk({tag, "_pc"}, 32'(PC), 32'(RESET_PC));
        chk({tag, "_addr"}, 32'(MEM_ADDR), 32'(RESET_PC));
        chk({tag, "_rd"}, 32'(MEM_RD), 32'd0);
    endtask

    // Monitor: compares head/PC against the model and retires bytes on each take.
    initial begin
        logic ev;
        forever begin
            @(negedge CLK);
            #2;
            if (mon_en) begin
                ev = (exp_q.size() > 0) &&
                     ((exp_q[0].cyc <= cyc - 2) || (BYP && exp_q[0].cyc == cyc - 1 && !JUMP));
                chk("instr_valid", 32'(INSTR_VALID), 32'(ev));
                chk("instr", 32'(INSTR), ev ? 32'(mem_byte(exp_q[0].addr)) : 32'd0);
                chk("pc", 32'(PC), 32'(exp_pc));
                if (JUMP) begin
                    exp_q.delete();
                    exp_pc = JUMP_ADDR;
                    $display("cycle %0d: jump to %h", cyc, JUMP_ADDR);
                end else if (INSTR_TAKE && ev) begin
                    $display("cycle %0d: take %h at pc %h", cyc, INSTR, PC);
                    chk("take_pc", 32'(PC), 32'(exp_q[0].addr));
                    void'(exp_q.pop_front());
                    exp_pc = exp_pc + 16'd1;
                end
            end
        end
    end

    initial begin
        logic [15:0] ja;
        // Held in reset
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        reset_checks("reset");

        // Release, no takes: exactly FIFO_DEPTH requests then MEM_RD stays low
        rst_req = 1'b1;
        n_issue = 0;
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("fill_issues", 32'(n_issue), 32'(FIFO_DEPTH));

        // Continuous takes
        repeat (12) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);

        // Jump with 3 queued and 1 in flight
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("pre_jump_inflight", 32'(exp_q.size()), 32'd4);
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h8000);
        step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        chk("jump_valid", 32'(INSTR_VALID), 32'd0);
        chk("jump_pc", 32'(PC), 32'h8000);
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);

        // Address wrap FFFF -> 0000
        step(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE);
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        chk("wrap_pc", 32'(PC), 32'h0005);

        // Grant toggling, HALT from the 10th cycle, queue drains
        for (int i = 0; i < 24; i++)
            step(1'(i % 2 == 0), 1'(i >= 10), 1'($urandom_range(0, 1)), 1'b0, 16'h0);
        repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
        chk("halt_drained", 32'(INSTR_VALID), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 2))
                0:       ja = 16'h8000;
                1:       ja = 16'hFFFE;
                default: ja = 16'($urandom);
            endcase
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), ja);
        end

        // Asynchronous reset pulse between edges
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        #2;
        RST_bar = 1'b0;
        #1;
        reset_checks("async_reset");
        exp_q.delete();
        exp_pc     = RESET_PC;
        nf         = RESET_PC;
        last_issue = 1'b0;
        mon_en     = 1'b0;
        rst_req    = 1'b0;
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
        rst_req = 1'b1;
        repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
